// File: rtl/block_ram_bus_pkg.sv
// Shared definitions for the on-chip RAM bus slave: bus direction encoding,
// handshake FSM state encoding and the word-index range helper.
package block_ram_bus_pkg;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_DONE = 1'b1;

  // Full 32-bit compare so high address bits can never alias into the array.
  function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned size);
    return idx < size;
  endfunction

endpackage

// File: rtl/block_ram_bus_array.sv
// Synchronous-read storage array: one write port and one registered read port
// sharing a clock, shaped so vendor tools map it onto block RAM.
module block_ram_bus_array #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32'h4000,
  parameter int unsigned AW        = 14,
  parameter string       INIT_FILE = ""
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    widx_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    ridx_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array or its read register, otherwise block RAM inference is lost.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/block_ram_bus.sv
// Single-port RAM slave for the CPU system bus with a request/ready handshake.
// Performs exactly one access per request and completes out-of-range accesses.
module block_ram_bus
  import block_ram_bus_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SIZE      = 32'h4000,
  parameter int unsigned ADDR_LSH  = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_request,
  input  logic             i_rw,
  input  logic [31:0]      i_address,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_ready
);

  localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  // Forces o_rdata to zero after reset or an out-of-range read, since the
  // array read register itself cannot be reset.
  logic   rd_zero_q, rd_zero_d;

  logic [31:0]      idx;
  logic [AW-1:0]    word;
  logic             in_range;
  logic             ram_we;
  logic             ram_re;
  logic [WIDTH-1:0] ram_rdata;

  always_comb begin
    idx      = i_address >> ADDR_LSH;
    word     = idx[AW-1:0];
    in_range = idx_in_range(idx, SIZE);
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    rd_zero_d = rd_zero_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_request) begin
          ram_we  = (i_rw == BUS_WRITE) && in_range;
          ram_re  = (i_rw == BUS_READ) && in_range;
          ready_d = 1'b1;
          state_d = ST_DONE;
          if (i_rw == BUS_READ) begin
            rd_zero_d = !in_range;
          end
        end
      end
      ST_DONE: begin
        if (!i_request) begin
          ready_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  block_ram_bus_array #(
    .WIDTH    (WIDTH),
    .DEPTH    (SIZE),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk_i  (i_clock),
    .we_i   (ram_we),
    .widx_i (word),
    .wdata_i(i_wdata),
    .re_i   (ram_re),
    .ridx_i (word),
    .rdata_o(ram_rdata)
  );

  assign o_rdata = rd_zero_q ? '0 : ram_rdata;
  assign o_ready = ready_q;

endmodule

// File: tb/tb_block_ram_bus.sv
// Directed bench for block_ram_bus: reset, read/write, handshake hold,
// word mapping, out-of-range handling and reset during an access.
module tb_block_ram_bus;

  logic        clk;
  logic        i_reset;
  logic        i_request;
  logic        i_rw;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;

  int errors = 0;
  int checks = 0;

  block_ram_bus dut (
    .i_clock  (clk),
    .i_reset  (i_reset),
    .i_request(i_request),
    .i_rw     (i_rw),
    .i_address(i_address),
    .i_wdata  (i_wdata),
    .o_rdata  (o_rdata),
    .o_ready  (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete access; lat = cycles from request to o_ready, -1 on timeout.
  // Called and returns at posedge + 1.
  task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
    i_rw      = rw;
    i_address = addr;
    i_wdata   = wd;
    i_request = 1'b1;
    lat       = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (o_ready === 1'b1) begin
        lat = c;
        break;
      end
    end
    rd        = o_rdata;
    i_request = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset   = 1'b0;
    i_request = 1'b0;
    i_rw      = 1'b0;
    i_address = '0;
    i_wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", o_ready);
    end
    checks++;
    if (o_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00000000", o_rdata);
    end
    i_reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ready cycle %0d: got %b want 0", c, o_ready);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int lat;
    do_access(1'b1, 32'h10, 32'hDEADBEEF, rd, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL wr_latency: got %0d want 1", lat);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready_drop: got %b want 0", o_ready);
    end
    do_access(1'b0, 32'h10, 32'h0, rd, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL rd_latency: got %0d want 1", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_data: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_handshake();
    logic [31:0] rd;
    int lat;
    do_access(1'b1, 32'h44, 32'h12345678, rd, lat);
    do_access(1'b1, 32'h20, 32'hA5A5A5A5, rd, lat);
    // Held read: address moves after the first edge; output must not follow it.
    i_rw      = 1'b0;
    i_address = 32'h20;
    i_request = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      i_address = 32'h10;
      checks++;
      if (o_ready !== 1'b1 || o_rdata !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL hold_read cycle %0d: got ready=%b data=%h want ready=1 data=a5a5a5a5",
                 c, o_ready, o_rdata);
      end
    end
    i_request = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL hold_release: got ready=%b data=%h want ready=0 data=a5a5a5a5",
               o_ready, o_rdata);
    end
    // Held write: a second access would land at the moved address.
    i_rw      = 1'b1;
    i_address = 32'h40;
    i_wdata   = 32'h5A5A5A5A;
    i_request = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      i_address = 32'h44;
    end
    i_request = 1'b0;
    @(posedge clk);
    #1;
    do_access(1'b0, 32'h44, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++;
      $display("FAIL single_write_other: got %h want 12345678", rd);
    end
    do_access(1'b0, 32'h40, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL single_write_target: got %h want 5a5a5a5a", rd);
    end
  endtask

  task automatic test_word_mapping();
    logic [31:0] rd;
    int lat;
    do_access(1'b1, 32'h0, 32'h11111111, rd, lat);
    do_access(1'b1, 32'h4, 32'h22222222, rd, lat);
    do_access(1'b0, 32'h4, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h22222222) begin
      errors++;
      $display("FAIL map_word1: got %h want 22222222", rd);
    end
    do_access(1'b0, 32'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++;
      $display("FAIL map_word0: got %h want 11111111", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int lat;
    do_access(1'b0, 32'h00010000, 32'h0, rd, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL oor_rd_latency: got %0d want 1", lat);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_rd_data: got %h want 00000000", rd);
    end
    do_access(1'b1, 32'h00010000, 32'hCAFEF00D, rd, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL oor_wr_latency: got %0d want 1", lat);
    end
    do_access(1'b0, 32'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++;
      $display("FAIL oor_wr_alias: got %h want 11111111", rd);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd;
    int lat;
    i_rw      = 1'b0;
    i_address = 32'h10;
    i_request = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_ready: got %b want 1", o_ready);
    end
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async: got ready=%b data=%h want ready=0 data=00000000",
               o_ready, o_rdata);
    end
    @(posedge clk);
    #1;
    i_request = 1'b0;
    i_reset   = 1'b1;
    @(posedge clk);
    #1;
    do_access(1'b0, 32'h10, 32'h0, rd, lat);
    checks++;
    if (lat !== 1 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midrst_retain: got lat=%0d data=%h want lat=1 data=deadbeef", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_handshake();
    test_word_mapping();
    test_out_of_range();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
